fila_andar_a: RTL and testbench

Passenger queue and boarding controller at floor A, directly upstream of the elevator FSM.
- Counts people arriving at floor A from a raw switch.
- Holds them in a waiting count.
- Drives the elevator's one-bit `pessoa` input: one pulse per boarding person, only while the door is open at floor A and the elevator is below capacity.
- Consumes the elevator's `porta` and `andar` outputs.

---
 rtl/fila_andar_a_if.sv | 25 ++
 rtl/fila_andar_a.sv | 107 ++++++++++
 tb/tb_fila_andar_a.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fila_andar_a_if.sv
// Signal bundle between the floor-A queue controller and its environment
// (arrival switch, elevator door/floor in; boarding strobe and status out).
interface fila_andar_a_if #(
  parameter int FILA_BITS = 3
);
  logic                 chegada;
  logic                 porta;
  logic                 andar;
  logic                 pessoa;
  logic [FILA_BITS-1:0] fila;
  logic [1:0]           embarcados;
  logic                 cheia;
  logic [1:0]           estado;
  logic                 overflow;

  modport master (
    output chegada, porta, andar,
    input  pessoa, fila, embarcados, cheia, estado, overflow
  );

  modport slave (
    input  chegada, porta, andar,
    output pessoa, fila, embarcados, cheia, estado, overflow
  );
endinterface

// File: rtl/fila_andar_a.sv
// Floor-A passenger queue and boarding controller feeding the elevator FSM.
// Optional sticky overflow flag built only with FILA_OVERFLOW_STICKY_EN.
module fila_andar_a #(
  parameter int CAP       = 2,
  parameter int MAX_FILA  = 7,
  parameter int FILA_BITS = 3
) (
  input  logic           clk_2,
  input  logic           reset,
  fila_andar_a_if.slave  bus
);

  localparam logic [1:0] AUSENTE  = 2'd0;
  localparam logic [1:0] EMBARQUE = 2'd1;
  localparam logic [1:0] LOTADO   = 2'd2;

  localparam logic [1:0]           CAP_L = 2'(CAP);
  localparam logic [FILA_BITS-1:0] MAX_L = FILA_BITS'(MAX_FILA);
  localparam logic [FILA_BITS-1:0] ONE_F = {{(FILA_BITS-1){1'b0}}, 1'b1};

  logic                 s1_q, s2_q, s3_q;
  logic [1:0]           st_q, st_d;
  logic [FILA_BITS-1:0] fila_q, fila_d;
  logic [1:0]           emb_q, emb_d;
  logic                 arrival, porta_a, pessoa, full;

  // s1/s2 resynchronize the raw switch; s3 is only for edge detection
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.chegada;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign arrival = s2_q & ~s3_q;
  assign porta_a = bus.porta & ~bus.andar;
  assign full    = (fila_q == MAX_L);
  assign pessoa  = (st_q == EMBARQUE) & porta_a & (fila_q != '0) & (emb_q < CAP_L);

  always_comb begin
    st_d = st_q;
    case (st_q)
      AUSENTE:  if (porta_a) st_d = EMBARQUE;
      EMBARQUE: begin
        // door closing wins over reaching capacity
        if (!porta_a)                                 st_d = AUSENTE;
        else if (pessoa && (emb_q + 2'd1 == CAP_L))   st_d = LOTADO;
      end
      LOTADO:   if (!porta_a) st_d = AUSENTE;
      default:  st_d = AUSENTE;
    endcase
  end

  // Arrival and boarding on the same edge cancel out, even when full
  always_comb begin
    fila_d = fila_q;
    if (arrival && !pessoa && !full) fila_d = fila_q + ONE_F;
    else if (!arrival && pessoa)     fila_d = fila_q - ONE_F;
  end

  // pessoa already implies emb_q < CAP, so the increment saturates at CAP
  always_comb begin
    emb_d = emb_q;
    if (st_q == AUSENTE && porta_a) emb_d = 2'd0;
    else if (pessoa)                emb_d = emb_q + 2'd1;
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      st_q   <= AUSENTE;
      fila_q <= '0;
      emb_q  <= 2'd0;
    end else begin
      st_q   <= st_d;
      fila_q <= fila_d;
      emb_q  <= emb_d;
    end
  end

`ifdef FILA_OVERFLOW_STICKY_EN
  logic ovf_q;
  logic drop;

  assign drop = arrival & ~pessoa & full;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset)     ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.pessoa     = pessoa;
  assign bus.fila       = fila_q;
  assign bus.embarcados = emb_q;
  assign bus.cheia      = full;
  assign bus.estado     = st_q;

endmodule

// File: tb/tb_fila_andar_a.sv
// Directed bench for fila_andar_a: hand-computed expectations per cycle.
module tb_fila_andar_a;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fila_andar_a_if #(.FILA_BITS(3)) bif ();

  fila_andar_a #(.CAP(2), .MAX_FILA(7), .FILA_BITS(3)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge, settle 1 time unit past it
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      #1;
    end
  endtask

  // one switch press; the queue has absorbed it when this returns
  task automatic arrive();
    bif.chegada = 1'b1; tick(2);
    bif.chegada = 1'b0; tick(2);
  endtask

  int exp_ovf;

  initial begin
    bif.chegada = 1'b0;
    bif.porta   = 1'b1;
    bif.andar   = 1'b0;
    tick(2);
    chk("rst_estado", bif.estado, 0);
    chk("rst_fila",   bif.fila, 0);
    chk("rst_emb",    bif.embarcados, 0);
    chk("rst_pessoa", bif.pessoa, 0);
    chk("rst_ovf",    bif.overflow, 0);

    // door open at A with nobody waiting
    reset = 1'b0;
    tick();
    chk("s1_estado", bif.estado, 1);
    chk("s1_pessoa", bif.pessoa, 0);
    chk("s1_fila",   bif.fila, 0);

    // three arrivals with door closed, then open: two back-to-back boardings
    bif.porta = 1'b0;
    tick();
    chk("s2_away", bif.estado, 0);
    repeat (3) arrive();
    chk("s2_fila3", bif.fila, 3);
    bif.porta = 1'b1;
    tick();
    chk("s2_emb_st", bif.estado, 1);
    chk("s2_p1",     bif.pessoa, 1);
    chk("s2_emb0",   bif.embarcados, 0);
    tick();
    chk("s2_p2",     bif.pessoa, 1);
    chk("s2_fila2",  bif.fila, 2);
    tick();
    chk("s2_p3",     bif.pessoa, 0);
    chk("s2_fila1",  bif.fila, 1);
    chk("s2_emb2",   bif.embarcados, 2);
    chk("s2_lotado", bif.estado, 2);
    tick();
    chk("s2_hold",   bif.pessoa, 0);

    // reopen: one boarding leaves EMBARQUE with fila 0, then a single arrival
    bif.porta = 1'b0; tick();
    chk("s3_away", bif.estado, 0);
    bif.porta = 1'b1; tick();
    chk("s3_emb0", bif.embarcados, 0);
    tick();
    chk("s3_fila0", bif.fila, 0);
    chk("s3_emb1",  bif.embarcados, 1);
    chk("s3_st",    bif.estado, 1);
    bif.chegada = 1'b1;
    tick(2);
    chk("s3_nop", bif.pessoa, 0);
    tick();
    chk("s3_fila1", bif.fila, 1);
    chk("s3_pulse", bif.pessoa, 1);
    tick();
    chk("s3_fila_b", bif.fila, 0);
    chk("s3_pulse0", bif.pessoa, 0);
    chk("s3_emb2",   bif.embarcados, 2);
    chk("s3_lot",    bif.estado, 2);
    bif.chegada = 1'b0;
    bif.porta   = 1'b0;
    tick();
    chk("s3_close", bif.estado, 0);
    chk("s3_fila",  bif.fila, 0);

    // arrival coincides with a boarding edge at fila 2
    repeat (2) arrive();
    chk("s5_fila2", bif.fila, 2);
    bif.chegada = 1'b1; tick();
    bif.porta   = 1'b1; tick();
    chk("s5_st",   bif.estado, 1);
    chk("s5_p",    bif.pessoa, 1);
    tick();
    chk("s5_fila", bif.fila, 2);
    chk("s5_emb1", bif.embarcados, 1);
    tick();
    chk("s5_fila1", bif.fila, 1);
    chk("s5_lot",   bif.estado, 2);
    bif.chegada = 1'b0;
    bif.porta   = 1'b0;
    tick(2);

    // reset mid-boarding at fila 3, embarcados 1
    repeat (3) arrive();
    chk("s6_fila4", bif.fila, 4);
    bif.porta = 1'b1; tick();
    tick();
    chk("s6_fila3", bif.fila, 3);
    chk("s6_emb1",  bif.embarcados, 1);
    reset = 1'b1;
    #1;
    chk("s6_fila",   bif.fila, 0);
    chk("s6_emb",    bif.embarcados, 0);
    chk("s6_estado", bif.estado, 0);
    chk("s6_pessoa", bif.pessoa, 0);
    bif.porta = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // fill the queue; the eighth arrival is dropped
    repeat (7) arrive();
    chk("s4_fila7",  bif.fila, 7);
    chk("s4_cheia",  bif.cheia, 1);
    chk("s4_ovf_pre", bif.overflow, 0);
    arrive();
    chk("s4_fila_sat", bif.fila, 7);
    chk("s4_cheia2",   bif.cheia, 1);
`ifdef FILA_OVERFLOW_STICKY_EN
    exp_ovf = 1;
`else
    exp_ovf = 0;
`endif
    chk("s4_ovf", bif.overflow, exp_ovf);

    // arrival at MAX_FILA together with a boarding is kept
    bif.chegada = 1'b1; tick();
    bif.porta   = 1'b1; tick();
    chk("s7_p", bif.pessoa, 1);
    tick();
    chk("s7_fila", bif.fila, 7);
    chk("s7_emb",  bif.embarcados, 1);
    chk("s7_ovf",  bif.overflow, exp_ovf);
    tick();
    chk("s7_fila6", bif.fila, 6);
    chk("s7_cheia", bif.cheia, 0);
    bif.chegada = 1'b0;
    bif.porta   = 1'b0;
    tick(2);
    chk("s7_sticky", bif.overflow, exp_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
